apu_frame_len_env: RTL and testbench
====================================

Name: apu_frame_len_env

Overview:
- Parametrised successor to the per-channel length-counter gating in the NES PAPU.
- One frame sequencer drives a bank of NUM_CH channel slices. Each slice has a length counter, a halt flag, an enable bit and an envelope generator.
- Produces the gated 4-bit volume per channel, the length-active status ($4015 read bits), quarter/half-frame strobes for sweep units, and the frame IRQ.
- Sits between the CPU register-write decode and the waveform generators / mixer tables.

Parameters:
- NUM_CH, 4, number of channel slices (1..8).
- FRAME_DIV, 7457, clk cycles per frame-sequencer step (quarter-frame period).
- CH_W, $clog2(NUM_CH) (minimum 1), width of wr_chan.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  synchronous active-low reset.
- wr_en  in  1  register write strobe, single cycle.
- wr_sel  in  2  write target: 0 = channel control, 1 = channel length load, 2 = enable mask ($4015), 3 = frame control ($4017).
- wr_chan  in  CH_W  channel index for wr_sel 0/1. Ignored for wr_sel 2/3.
- wr_data  in  8  write data.
- irq_ack  in  1  clears frame_irq ($4015 read side effect).
- vol_out  out  4*NUM_CH  gated volume, channel i at [4i+3:4i].
- len_active  out  NUM_CH  bit i = length counter i nonzero.
- quarter_tick  out  1  one-cycle strobe on each quarter-frame event.
- half_tick  out  1  one-cycle strobe on each half-frame event.
- frame_irq  out  1  frame interrupt flag, level.

Behaviour:
- Reset (reset_n = 0 at clk edge):
  - Clears divider, step, mode, irq_inhibit, enable mask, all length counters, halt flags, const flags, vol/period values, envelope start/divider/decay.
  - All outputs are 0 while reset is asserted and in the first cycle after release.
  - Reset mid-sequence discards the pending tick.
- Divider: counts 0..FRAME_DIV-1. At terminal count it wraps to 0 and the sequencer advances one step.
- 4-step mode (mode = 0), steps 0..3:
  - quarter on every step.
  - half on steps 1 and 3.
  - step 3 sets frame_irq unless irq_inhibit is set.
  - step wraps 3 -> 0.
- 5-step mode (mode = 1), steps 0..4:
  - quarter on steps 0, 1, 2, 4; none on step 3.
  - half on steps 1 and 4.
  - never sets frame_irq.
  - step wraps 4 -> 0.
- Ticks are registered: quarter_tick/half_tick assert the cycle after the divider wraps. Slices act on the tick in that same cycle.
- Frame control write (wr_sel 3):
  - mode = wr_data[7], irq_inhibit = wr_data[6].
  - divider and step reset to 0.
  - If wr_data[7] = 1, quarter_tick and half_tick fire the next cycle.
  - If wr_data[6] = 1, frame_irq clears.
- frame_irq clears on irq_ack. If a set and a clear land in the same cycle, set wins.
- Channel control write (wr_sel 0): halt/loop = d[5], const = d[4], vol/period = d[3:0].
- Length load (wr_sel 1):
  - If enable[ch] = 1: length = LEN_TABLE[d[7:3]] and envelope start flag is set.
  - If enable[ch] = 0: ignored.
- Enable write (wr_sel 2): enable = d[NUM_CH-1:0]. Every channel whose bit is 0 has its length forced to 0 in the same cycle.
- Half tick: per channel, if length != 0 and halt = 0, length decrements by 1. No wrap below 0.
- Quarter tick, per channel:
  - If start flag is set: clear it, decay = 15, env_div = period.
  - Else if env_div = 0: env_div = period, then:
    - if decay != 0, decay decrements;
    - else if loop is set, decay = 15.
  - Else env_div decrements.
- Same-cycle priority:
  - enable clear > length load > half-tick decrement.
  - A tick coinciding with a control write uses the old halt/period values.
- vol_out[i] = (length_i == 0) ? 0 : (const_i ? vol_i : decay_i). Registered, one cycle after the state update.
- len_active[i] = (length_i != 0), combinational from the state.

Decomposition:
- Package apu_pkg holds:
  - LEN_TABLE[0:31] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30;
  - wr_sel encodings;
  - step/mode constants.
- Sub-module apu_chan_slice (length counter + halt + envelope), instantiated NUM_CH times by generate. The frame sequencer stays in the top level.

Test Plan:
- Reset release, FRAME_DIV = 4, mode 0 -> quarter_tick every 4 cycles; half_tick on steps 1 and 3; frame_irq = 1 after step 3; irq_ack -> frame_irq = 0.
- Enable = 0x1, ch0 control = 0x10 | 0x9, length load d = 0x08 (index 1) -> len_active[0] = 1, vol_out[0] = 9; after 254 half ticks len_active[0] = 0, vol_out[0] = 0.
- Enable = 0x0, then length load on ch1 -> len_active[1] stays 0. Enable ch1, load index 0, then write enable = 0 -> length cleared the same cycle.
- ch2 control = 0x20 | 0x1 (loop, period 1), length load -> vol_out[2] reads 15, then decrements every 2 quarter ticks to 0, then reloads 15; halt keeps length constant.
- Frame write 0x80 -> immediate quarter_tick + half_tick the next cycle, 5-step pattern (no quarter on step 3), frame_irq never set. Frame write 0x40 while frame_irq = 1 -> frame_irq cleared.
- Length load coinciding with half_tick on the same channel -> length = table value, not table value - 1.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants for the APU frame sequencer and channel length/envelope slices.
// Includes the write-target encodings, sequencer step limits and the length-load table.
package apu_pkg;

   localparam int unsigned LEN_W  = 8;
   localparam int unsigned ENV_W  = 4;
   localparam int unsigned STEP_W = 3;

   typedef enum logic [1:0] {
      SEL_CTRL   = 2'd0,
      SEL_LEN    = 2'd1,
      SEL_ENABLE = 2'd2,
      SEL_FRAME  = 2'd3
   } wr_sel_e;

   localparam logic MODE_4STEP = 1'b0;
   localparam logic MODE_5STEP = 1'b1;

   localparam logic [STEP_W-1:0] STEP_LAST_4 = 3'd3;
   localparam logic [STEP_W-1:0] STEP_LAST_5 = 3'd4;

   // Index 0 is the leftmost entry (ascending packed range).
   localparam logic [0:31][LEN_W-1:0] LEN_TABLE = {
      8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
      8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
      8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
      8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
   };

   function automatic logic [LEN_W-1:0] len_lookup(input logic [4:0] idx);
      return LEN_TABLE[idx];
   endfunction

endpackage

// File: rtl/apu_chan_slice.sv
// One channel slice: enable bit, length counter with halt, and envelope generator.
// Produces the registered gated volume and the combinational length-active flag.
module apu_chan_slice
   import apu_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             quarter_i,
   input  logic             half_i,
   input  logic             ctrl_we_i,
   input  logic             len_we_i,
   input  logic             en_we_i,
   input  logic             en_bit_i,
   input  logic [7:0]       wr_data_i,
   output logic [ENV_W-1:0] vol_o,
   output logic             len_active_o
);

   logic             en_q,      en_d;
   logic [LEN_W-1:0] len_q,     len_d;
   logic             halt_q,    halt_d;
   logic             const_q,   const_d;
   logic [ENV_W-1:0] param_q,   param_d;
   logic             start_q,   start_d;
   logic [ENV_W-1:0] env_div_q, env_div_d;
   logic [ENV_W-1:0] decay_q,   decay_d;
   logic [ENV_W-1:0] out_q,     out_d;
   logic             load_ok;

   assign load_ok = len_we_i & en_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         en_q      <= 1'b0;
         len_q     <= '0;
         halt_q    <= 1'b0;
         const_q   <= 1'b0;
         param_q   <= '0;
         start_q   <= 1'b0;
         env_div_q <= '0;
         decay_q   <= '0;
         out_q     <= '0;
      end else begin
         en_q      <= en_d;
         len_q     <= len_d;
         halt_q    <= halt_d;
         const_q   <= const_d;
         param_q   <= param_d;
         start_q   <= start_d;
         env_div_q <= env_div_d;
         decay_q   <= decay_d;
         out_q     <= out_d;
      end
   end

   always_comb begin
      en_d      = en_q;
      len_d     = len_q;
      halt_d    = halt_q;
      const_d   = const_q;
      param_d   = param_q;
      start_d   = start_q;
      env_div_d = env_div_q;
      decay_d   = decay_q;

      if (ctrl_we_i) begin
         halt_d  = wr_data_i[5];
         const_d = wr_data_i[4];
         param_d = wr_data_i[3:0];
      end

      if (en_we_i) begin
         en_d = en_bit_i;
      end

      // Enable clear beats a load, which beats a half-frame decrement.
      if (en_we_i && !en_bit_i) begin
         len_d = '0;
      end else if (load_ok) begin
         len_d = len_lookup(wr_data_i[7:3]);
      end else if (half_i && (len_q != '0) && !halt_q) begin
         len_d = len_q - LEN_W'(1);
      end

      // Ticks see the pre-write halt/period because they read the _q values.
      if (quarter_i) begin
         if (start_q) begin
            start_d   = 1'b0;
            decay_d   = 4'd15;
            env_div_d = param_q;
         end else if (env_div_q == '0) begin
            env_div_d = param_q;
            if (decay_q != '0) begin
               decay_d = decay_q - ENV_W'(1);
            end else if (halt_q) begin
               decay_d = 4'd15;
            end
         end else begin
            env_div_d = env_div_q - ENV_W'(1);
         end
      end

      if (load_ok) begin
         start_d = 1'b1;
      end
   end

   always_comb begin
      out_d = '0;
      if (len_q != '0) begin
         out_d = const_q ? param_q : decay_q;
      end
   end

   assign vol_o        = out_q;
   assign len_active_o = (len_q != '0);

endmodule

// File: rtl/apu_frame_len_env.sv
// Frame sequencer driving NUM_CH length/envelope slices; emits quarter/half strobes,
// the frame IRQ, gated channel volumes and length-active status.
module apu_frame_len_env
   import apu_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned FRAME_DIV = 7457,
   parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [1:0]            wr_sel,
   input  logic [CH_W-1:0]       wr_chan,
   input  logic [7:0]            wr_data,
   input  logic                  irq_ack,
   output logic [4*NUM_CH-1:0]   vol_out,
   output logic [NUM_CH-1:0]     len_active,
   output logic                  quarter_tick,
   output logic                  half_tick,
   output logic                  frame_irq
);

   localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   logic [DIV_W-1:0]  div_q,     div_d;
   logic [STEP_W-1:0] step_q,    step_d;
   logic              mode_q,    mode_d;
   logic              inhibit_q, inhibit_d;
   logic              irq_q,     irq_d;
   logic              quarter_q, quarter_d;
   logic              half_q,    half_d;
   logic              irq_set;
   logic              wrap;
   logic [STEP_W-1:0] step_last;

   wr_sel_e sel;
   logic    frame_we;
   logic    ctrl_we;
   logic    len_we;
   logic    en_we;

   assign sel      = wr_sel_e'(wr_sel);
   assign frame_we = wr_en && (sel == SEL_FRAME);
   assign ctrl_we  = wr_en && (sel == SEL_CTRL);
   assign len_we   = wr_en && (sel == SEL_LEN);
   assign en_we    = wr_en && (sel == SEL_ENABLE);

   assign wrap      = (div_q == DIV_W'(FRAME_DIV - 1));
   assign step_last = (mode_q == MODE_5STEP) ? STEP_LAST_5 : STEP_LAST_4;

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_q     <= '0;
         step_q    <= '0;
         mode_q    <= MODE_4STEP;
         inhibit_q <= 1'b0;
         irq_q     <= 1'b0;
         quarter_q <= 1'b0;
         half_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         step_q    <= step_d;
         mode_q    <= mode_d;
         inhibit_q <= inhibit_d;
         irq_q     <= irq_d;
         quarter_q <= quarter_d;
         half_q    <= half_d;
      end
   end

   // Next divider/step/mode; a frame write restarts the sequence
   always_comb begin
      div_d     = div_q + DIV_W'(1);
      step_d    = step_q;
      mode_d    = mode_q;
      inhibit_d = inhibit_q;
      if (frame_we) begin
         mode_d    = wr_data[7];
         inhibit_d = wr_data[6];
         div_d     = '0;
         step_d    = '0;
      end else if (wrap) begin
         div_d  = '0;
         step_d = (step_q == step_last) ? '0 : step_q + STEP_W'(1);
      end
   end

   // Tick and IRQ decode for the step that is completing
   always_comb begin
      quarter_d = 1'b0;
      half_d    = 1'b0;
      irq_set   = 1'b0;
      if (frame_we) begin
         quarter_d = wr_data[7];
         half_d    = wr_data[7];
      end else if (wrap) begin
         if (mode_q == MODE_4STEP) begin
            quarter_d = 1'b1;
            half_d    = (step_q == 3'd1) || (step_q == 3'd3);
            irq_set   = (step_q == 3'd3) && !inhibit_q;
         end else begin
            quarter_d = (step_q != 3'd3);
            half_d    = (step_q == 3'd1) || (step_q == 3'd4);
         end
      end

      irq_d = irq_q;
      if (irq_set) begin
         irq_d = 1'b1;
      end else if (irq_ack || (frame_we && wr_data[6])) begin
         irq_d = 1'b0;
      end
   end

   assign quarter_tick = quarter_q;
   assign half_tick    = half_q;
   assign frame_irq    = irq_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slice
      logic ch_hit;
      assign ch_hit = (wr_chan == CH_W'(i));

      apu_chan_slice u_slice (
         .clk          (clk),
         .reset_n      (reset_n),
         .quarter_i    (quarter_q),
         .half_i       (half_q),
         .ctrl_we_i    (ctrl_we && ch_hit),
         .len_we_i     (len_we && ch_hit),
         .en_we_i      (en_we),
         .en_bit_i     (wr_data[i]),
         .wr_data_i    (wr_data),
         .vol_o        (vol_out[4*i +: 4]),
         .len_active_o (len_active[i])
      );
   end

endmodule

// File: tb/tb_apu_frame_len_env.sv
// Directed bench for apu_frame_len_env with a short frame divider (4 clocks per step).
module tb_apu_frame_len_env;

   localparam int unsigned NUM_CH    = 4;
   localparam int unsigned FRAME_DIV = 4;
   localparam int unsigned CH_W      = 2;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                wr_en;
   logic [1:0]          wr_sel;
   logic [CH_W-1:0]     wr_chan;
   logic [7:0]          wr_data;
   logic                irq_ack;
   logic [4*NUM_CH-1:0] vol_out;
   logic [NUM_CH-1:0]   len_active;
   logic                quarter_tick;
   logic                half_tick;
   logic                frame_irq;

   int checks = 0;
   int errors = 0;
   int pre;

   always #5 clk = ~clk;

   apu_frame_len_env #(
      .NUM_CH    (NUM_CH),
      .FRAME_DIV (FRAME_DIV),
      .CH_W      (CH_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (wr_en),
      .wr_sel       (wr_sel),
      .wr_chan      (wr_chan),
      .wr_data      (wr_data),
      .irq_ack      (irq_ack),
      .vol_out      (vol_out),
      .len_active   (len_active),
      .quarter_tick (quarter_tick),
      .half_tick    (half_tick),
      .frame_irq    (frame_irq)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] sel, input logic [CH_W-1:0] ch, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_chan = ch;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   // Waits for n half ticks and for each to be applied by the slices.
   task automatic wait_half(input int n);
      for (int k = 0; k < n; k++) begin
         int cnt;
         cnt = 0;
         while (half_tick !== 1'b1 && cnt < 64) begin
            step();
            cnt++;
         end
         if (cnt >= 64) begin
            checks++;
            errors++;
            $display("FAIL half_timeout: observed no half_tick within 64 cycles, expected one");
         end
         step();
      end
   endtask

   task automatic wait_quarter(input int n);
      for (int k = 0; k < n; k++) begin
         int cnt;
         cnt = 0;
         while (quarter_tick !== 1'b1 && cnt < 64) begin
            step();
            cnt++;
         end
         if (cnt >= 64) begin
            checks++;
            errors++;
            $display("FAIL quarter_timeout: observed no quarter_tick within 64 cycles, expected one");
         end
         step();
      end
   endtask

   initial begin
      reset_n = 1'b0;
      wr_en   = 1'b0;
      wr_sel  = 2'd0;
      wr_chan = '0;
      wr_data = 8'h00;
      irq_ack = 1'b0;
      step();
      step();
      step();
      chk("rst_vol", 32'(vol_out), 32'h0);
      chk("rst_len", 32'(len_active), 32'h0);
      chk("rst_quarter", 32'(quarter_tick), 32'h0);
      chk("rst_half", 32'(half_tick), 32'h0);
      chk("rst_irq", 32'(frame_irq), 32'h0);

      reset_n = 1'b1;
      step();
      chk("rel_quarter", 32'(quarter_tick), 32'h0);
      chk("rel_half", 32'(half_tick), 32'h0);
      chk("rel_irq", 32'(frame_irq), 32'h0);
      chk("rel_vol", 32'(vol_out), 32'h0);

      // 4-step sequence: cycle c counts clock edges since reset release
      for (int c = 2; c <= 20; c++) begin
         step();
         chk($sformatf("seq4_q_c%0d", c), 32'(quarter_tick), 32'((c % 4) == 0));
         chk($sformatf("seq4_h_c%0d", c), 32'(half_tick), 32'((c == 8) || (c == 16)));
         chk($sformatf("seq4_irq_c%0d", c), 32'(frame_irq), 32'(c >= 16));
      end
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      chk("irq_ack_clear", 32'(frame_irq), 32'h0);

      // ch0: constant volume 9, length 254 counts down to zero
      wr(2'd2, 2'd0, 8'h01);
      wr(2'd0, 2'd0, 8'h19);
      wr(2'd1, 2'd0, 8'h08);
      chk("ch0_len_loaded", 32'(len_active[0]), 32'h1);
      pre = int'(half_tick);
      step();
      chk("ch0_vol_const", 32'(vol_out[3:0]), 32'h9);
      wait_half(253 - pre);
      chk("ch0_len_253", 32'(len_active[0]), 32'h1);
      wait_half(1);
      chk("ch0_len_254", 32'(len_active[0]), 32'h0);
      chk("ch0_vol_lag", 32'(vol_out[3:0]), 32'h9);
      step();
      chk("ch0_vol_zero", 32'(vol_out[3:0]), 32'h0);

      // ch1: load ignored while disabled; enable clear wipes length at once
      wr(2'd2, 2'd0, 8'h00);
      wr(2'd1, 2'd1, 8'h08);
      chk("ch1_load_disabled", 32'(len_active[1]), 32'h0);
      wr(2'd2, 2'd0, 8'h02);
      wr(2'd1, 2'd1, 8'h00);
      chk("ch1_load_enabled", 32'(len_active[1]), 32'h1);
      wr(2'd2, 2'd0, 8'h00);
      chk("ch1_enable_clear", 32'(len_active[1]), 32'h0);

      // ch2: looping envelope period 1, halted length 2
      wr(2'd2, 2'd0, 8'h04);
      wr(2'd0, 2'd2, 8'h21);
      wr(2'd1, 2'd2, 8'h18);
      wait_quarter(1);
      step();
      chk("ch2_env_start", 32'(vol_out[11:8]), 32'd15);
      wait_quarter(2);
      step();
      chk("ch2_env_14", 32'(vol_out[11:8]), 32'd14);
      wait_quarter(26);
      step();
      chk("ch2_env_1", 32'(vol_out[11:8]), 32'd1);
      wait_quarter(2);
      step();
      chk("ch2_env_0", 32'(vol_out[11:8]), 32'd0);
      wait_quarter(2);
      step();
      chk("ch2_env_loop", 32'(vol_out[11:8]), 32'd15);
      chk("ch2_halt_len", 32'(len_active[2]), 32'h1);

      // ch3: load landing on a half tick keeps the full table value
      wr(2'd2, 2'd0, 8'h08);
      chk("ch2_disabled_clear", 32'(len_active[2]), 32'h0);
      wr(2'd0, 2'd3, 8'h00);
      begin
         int cnt;
         cnt = 0;
         while (half_tick !== 1'b1 && cnt < 64) begin
            step();
            cnt++;
         end
         if (cnt >= 64) begin
            checks++;
            errors++;
            $display("FAIL ch3_sync_timeout: observed no half_tick within 64 cycles, expected one");
         end
      end
      wr(2'd1, 2'd3, 8'h18);
      wait_half(1);
      chk("ch3_len_after_1", 32'(len_active[3]), 32'h1);
      wait_half(1);
      chk("ch3_len_after_2", 32'(len_active[3]), 32'h0);

      // Frame control: 0x40 clears a pending IRQ, 0x80 starts 5-step mode
      chk("irq_pending", 32'(frame_irq), 32'h1);
      wr(2'd3, 2'd0, 8'h40);
      chk("irq_inhibit_clear", 32'(frame_irq), 32'h0);
      wr(2'd3, 2'd0, 8'h80);
      chk("seq5_imm_q", 32'(quarter_tick), 32'h1);
      chk("seq5_imm_h", 32'(half_tick), 32'h1);
      for (int c = 1; c <= 24; c++) begin
         step();
         chk($sformatf("seq5_q_c%0d", c), 32'(quarter_tick), 32'(((c % 4) == 0) && (c != 16)));
         chk($sformatf("seq5_h_c%0d", c), 32'(half_tick), 32'((c == 8) || (c == 20)));
         chk($sformatf("seq5_irq_c%0d", c), 32'(frame_irq), 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
